// File: rtl/nic8_pkg.sv
// nic8_pkg: shared types and constants for the nic8 sequencer slice.
// Holds the sequencer state encoding, instruction-register field positions,
// and the default width of the retired-instruction counter.
package nic8_pkg;

  // Sequencer states; the encoding is visible on debug taps, so it is fixed.
  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2,
    HALTED     = 2'd3
  } state_t;

  // Instruction register layout: [0] indexed, [3:1] source, [5:4] destination.
  localparam int INDEXED_BIT = 0;
  localparam int IR_SRC_LSB  = 1;
  localparam int IR_SRC_MSB  = 3;
  localparam int IR_DEST_LSB = 4;
  localparam int IR_DEST_MSB = 5;

  // Default retired-instruction counter width.
  localparam int COUNT_W_DEFAULT = 16;

  // An indexed instruction carries no immediate byte after the opcode.
  function automatic logic ir_is_indexed(input logic [7:0] ir_val);
    return ir_val[INDEXED_BIT];
  endfunction

endpackage

// File: rtl/nic8_instr_counter.sv
// nic8_instr_counter: retired-instruction counter, wraps at 2^COUNT_W.
// Synchronous clear has priority over increment.
module nic8_instr_counter
  import nic8_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] r_count;

  // Count retired instructions; natural binary wrap at the top value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: two-phase fetch/execute sequencer for the nic8 CPU.
// Owns the instruction boundary and the run/step/halt front-panel control.
// Optional feature: define NIC8_BREAKPOINT_EN to add a PC breakpoint
// (bp_valid/bp_addr inputs, bp_hit output).
module cpu_sequencer
  import nic8_pkg::*;
#(
  parameter int COUNT_W      = COUNT_W_DEFAULT,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [7:0]         ir,
  input  logic               do_jump,
  input  logic [7:0]         pc,
  output logic               pc_clear,
  output logic               fetch,
  output logic               exec_en,
  output logic               pc_inc,
  output logic               halted,
  output logic               step_done,
`ifdef NIC8_BREAKPOINT_EN
  input  logic               bp_valid,
  input  logic [7:0]         bp_addr,
  output logic               bp_hit,
`endif
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_hold;
  logic [3:0] w_hold_nxt;
  logic       r_step;
  logic       w_step_nxt;
  logic       r_step_done;
  logic       w_unused;

`ifdef NIC8_BREAKPOINT_EN
  // r_bp_arm: the current FETCH was entered by run (from EXEC or HALTED),
  // so the breakpoint compare applies; step-initiated fetches leave it clear.
  logic r_bp_arm;
  logic w_bp_arm_nxt;
  assign w_unused = ^ir[7:1];
`else
  assign w_unused = ^{ir[7:1], pc};
`endif

  // State register, reset-hold edge counter and single-step flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_HOLD;
      r_hold  <= 4'd0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_step  <= w_step_nxt;
    end
  end

`ifdef NIC8_BREAKPOINT_EN
  // Remember whether the upcoming fetch must be compared against bp_addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bp_arm <= 1'b0;
    end else begin
      r_bp_arm <= w_bp_arm_nxt;
    end
  end
`endif

  // Registered pulse: a stepped instruction retires at this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= (r_state == EXEC) & r_step;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_step_nxt  = r_step;
    pc_clear    = 1'b0;
    fetch       = 1'b0;
    exec_en     = 1'b0;
    pc_inc      = 1'b0;
    halted      = 1'b0;
`ifdef NIC8_BREAKPOINT_EN
    w_bp_arm_nxt = 1'b0;
    bp_hit       = 1'b0;
`endif
    case (r_state)
      RESET_HOLD: begin
        pc_clear = 1'b1;
        halted   = 1'b1;
        if (r_hold == HOLD_LAST) begin
          w_hold_nxt  = 4'd0;
          w_state_nxt = run ? FETCH : HALTED;
        end else begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      FETCH: begin
`ifdef NIC8_BREAKPOINT_EN
        if (r_bp_arm && bp_valid && (pc == bp_addr)) begin
          // Stop before loading the breakpoint instruction.
          bp_hit      = 1'b1;
          w_state_nxt = HALTED;
        end else begin
          fetch       = 1'b1;
          pc_inc      = 1'b1;
          w_state_nxt = EXEC;
        end
`else
        fetch       = 1'b1;
        pc_inc      = 1'b1;
        w_state_nxt = EXEC;
`endif
      end
      EXEC: begin
        exec_en = 1'b1;
        // Immediate operand byte is consumed unless a taken jump loads PC.
        pc_inc  = ~ir_is_indexed(ir) & ~do_jump;
        if (r_step) begin
          w_step_nxt  = 1'b0;
          w_state_nxt = HALTED;
        end else if (run) begin
          w_state_nxt = FETCH;
`ifdef NIC8_BREAKPOINT_EN
          w_bp_arm_nxt = 1'b1;
`endif
        end else begin
          w_state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (run) begin
          w_state_nxt = FETCH;
`ifdef NIC8_BREAKPOINT_EN
          w_bp_arm_nxt = 1'b1;
`endif
        end else if (step) begin
          w_step_nxt  = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = HALTED;
        end
      end
      default: begin
        w_state_nxt = RESET_HOLD;
        w_hold_nxt  = 4'd0;
        w_step_nxt  = 1'b0;
      end
    endcase
  end

  nic8_instr_counter #(
    .COUNT_W (COUNT_W)
  ) u_instr_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (r_state == RESET_HOLD),
    .inc   (r_state == EXEC),
    .count (instr_count)
  );

  assign step_done = r_step_done;

endmodule
